// File: rtl/pll_phase_sequencer.sv
// rtl/pll_phase_sequencer.sv - PLL dynamic-phase stepping / clock-switch sequencer with per-counter offsets
module pll_phase_sequencer #(
    parameter int SEL_W        = 3,
    parameter int NUM_SEL      = 7,
    parameter int STEP_W       = 8,
    parameter int OFS_W        = 12,
    parameter int SCAN_HALF    = 16,
    parameter int CLKSW_HOLD   = 8,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              phasedone,
    output logic [SEL_W-1:0]  phasecounterselect,
    output logic              phaseupdown,
    output logic              phasestep,
    output logic              scanclk,
    output logic              clkswitch,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_badsel,
    input  logic [SEL_W-1:0]  ofs_rd_sel,
    output logic [OFS_W-1:0]  ofs_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLKSW,
        S_STEP_SETUP,
        S_STEP_ASSERT,
        S_STEP_WAIT,
        S_DONE
    } state_t;

    localparam int DIV_W  = (SCAN_HALF > 1) ? $clog2(SCAN_HALF) : 1;
    localparam int HOLD_W = $clog2(CLKSW_HOLD + 1);
    localparam int TMO_W  = $clog2(DONE_TIMEOUT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_HALF - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLKSW_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DONE_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W+1)'(NUM_SEL);

    localparam logic signed [OFS_W-1:0] OFS_MAX = {1'b0, {(OFS_W-1){1'b1}}};
    localparam logic signed [OFS_W-1:0] OFS_MIN = {1'b1, {(OFS_W-1){1'b0}}};
    localparam logic signed [OFS_W-1:0] OFS_ONE = OFS_W'(1);

    state_t              state;
    logic [SEL_W-1:0]    sel_q;
    logic                dir_q;
    logic [STEP_W-1:0]   rem;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          rise_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                seen_low;
    logic                got_done;
    logic                aborted;
    logic                pd_meta;
    logic                pd_sync;
    logic                tick;
    logic [OFS_W-1:0]    rd_val;
    logic signed [OFS_W-1:0] acc [1:NUM_SEL-1];

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign tick      = (div_cnt == DIV_LAST);

    always_comb begin
        rd_val = '0;
        for (int i = 1; i < NUM_SEL; i++) begin
            if (ofs_rd_sel == SEL_W'(i)) begin
                rd_val = acc[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state              <= S_IDLE;
            sel_q              <= '0;
            dir_q              <= 1'b1;
            rem                <= '0;
            div_cnt            <= '0;
            rise_cnt           <= '0;
            hold_cnt           <= '0;
            tmo_cnt            <= '0;
            seen_low           <= 1'b0;
            got_done           <= 1'b0;
            aborted            <= 1'b0;
            pd_meta            <= 1'b1;
            pd_sync            <= 1'b1;
            phasecounterselect <= '0;
            phaseupdown        <= 1'b1;
            phasestep          <= 1'b0;
            scanclk            <= 1'b0;
            clkswitch          <= 1'b0;
            done               <= 1'b0;
            err_timeout        <= 1'b0;
            err_badsel         <= 1'b0;
            ofs_rd_data        <= '0;
            for (int i = 1; i < NUM_SEL; i++) begin
                acc[i] <= '0;
            end
        end else begin
            done        <= 1'b0;
            err_badsel  <= 1'b0;
            pd_meta     <= phasedone;
            pd_sync     <= pd_meta;
            ofs_rd_data <= rd_val;

            // scanclk free-runs from the divider only while a step is in flight
            if (state == S_STEP_ASSERT || state == S_STEP_WAIT) begin
                if (tick) begin
                    div_cnt <= '0;
                    scanclk <= ~scanclk;
                end else begin
                    div_cnt <= div_cnt + DIV_ONE;
                end
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        sel_q       <= cmd_sel;
                        dir_q       <= cmd_dir;
                        rem         <= cmd_steps;
                        err_timeout <= 1'b0;
                        if (cmd_op) begin
                            clkswitch <= 1'b1;
                            hold_cnt  <= '0;
                            state     <= S_CLKSW;
                        end else if ({1'b0, cmd_sel} >= SEL_LIMIT) begin
                            err_badsel <= 1'b1;
                        end else if (cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_STEP_SETUP;
                        end
                    end
                end

                S_CLKSW: begin
                    if (hold_cnt == HOLD_LAST) begin
                        clkswitch <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end

                S_STEP_SETUP: begin
                    phasecounterselect <= sel_q;
                    phaseupdown        <= dir_q;
                    scanclk            <= 1'b0;
                    phasestep          <= 1'b1;
                    div_cnt            <= '0;
                    rise_cnt           <= '0;
                    state              <= S_STEP_ASSERT;
                end

                S_STEP_ASSERT: begin
                    if (tick && !scanclk) begin
                        rise_cnt <= rise_cnt + 2'd1;
                    end
                    // phasestep is released on the falling scanclk edge after the second rise
                    if (tick && scanclk && rise_cnt == 2'd2) begin
                        phasestep <= 1'b0;
                        tmo_cnt   <= '0;
                        seen_low  <= 1'b0;
                        got_done  <= 1'b0;
                        aborted   <= 1'b0;
                        state     <= S_STEP_WAIT;
                    end
                end

                S_STEP_WAIT: begin
                    if (!got_done && !aborted) begin
                        if (!pd_sync) begin
                            seen_low <= 1'b1;
                        end
                        if (seen_low && pd_sync) begin
                            got_done <= 1'b1;
                            rem      <= rem - STEP_ONE;
                            for (int i = 1; i < NUM_SEL; i++) begin
                                if (sel_q == '0 || sel_q == SEL_W'(i)) begin
                                    if (dir_q && acc[i] != OFS_MAX) begin
                                        acc[i] <= acc[i] + OFS_ONE;
                                    end else if (!dir_q && acc[i] != OFS_MIN) begin
                                        acc[i] <= acc[i] - OFS_ONE;
                                    end
                                end
                            end
                        end else if (tmo_cnt == TMO_LAST) begin
                            aborted     <= 1'b1;
                            err_timeout <= 1'b1;
                            rem         <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_ONE;
                        end
                    end
                    if (got_done && tick && scanclk) begin
                        if (rem != '0) begin
                            state <= S_STEP_SETUP;
                        end else begin
                            done      <= 1'b1;
                            scanclk   <= 1'b0;
                            phasestep <= 1'b0;
                            state     <= S_DONE;
                        end
                    end
                    if (aborted && !scanclk) begin
                        done      <= 1'b1;
                        scanclk   <= 1'b0;
                        phasestep <= 1'b0;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    scanclk   <= 1'b0;
                    phasestep <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// tb/tb_pll_phase_sequencer.sv - self-checking bench for pll_phase_sequencer
module tb_pll_phase_sequencer;

    localparam int SEL_W        = 3;
    localparam int NUM_SEL      = 7;
    localparam int STEP_W       = 12;
    localparam int OFS_W        = 12;
    localparam int SCAN_HALF    = 2;
    localparam int CLKSW_HOLD   = 8;
    localparam int DONE_TIMEOUT = 4096;
    localparam int OMAX         = (1 << (OFS_W - 1)) - 1;
    localparam int OMIN         = -(1 << (OFS_W - 1));

    logic              clk = 1'b0;
    logic              rstn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [SEL_W-1:0]  cmd_sel;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;
    logic              phasedone;
    logic [SEL_W-1:0]  phasecounterselect;
    logic              phaseupdown;
    logic              phasestep;
    logic              scanclk;
    logic              clkswitch;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic              err_badsel;
    logic [SEL_W-1:0]  ofs_rd_sel;
    logic [OFS_W-1:0]  ofs_rd_data;

    pll_phase_sequencer #(
        .SEL_W(SEL_W), .NUM_SEL(NUM_SEL), .STEP_W(STEP_W), .OFS_W(OFS_W),
        .SCAN_HALF(SCAN_HALF), .CLKSW_HOLD(CLKSW_HOLD), .DONE_TIMEOUT(DONE_TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
        .phasedone(phasedone),
        .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
        .phasestep(phasestep), .scanclk(scanclk), .clkswitch(clkswitch),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_badsel(err_badsel),
        .ofs_rd_sel(ofs_rd_sel), .ofs_rd_data(ofs_rd_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic pd_stuck = 1'b0;
    int model_ofs [NUM_SEL];

    int done_cnt, bad_cnt, clksw_cyc, ps_pulses, ps_bad, sc_rises, busy_cyc;
    int last_clksw, done_at, ps_fall_at, tmo_at, ps_span;

    typedef struct {
        logic op;
        int   sel;
        logic dir;
        int   steps;
        int   exp_done;
        int   exp_bad;
        int   exp_ps;
        int   exp_clksw;
        int   exp_busy;
    } vec_t;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        done_cnt = 0; bad_cnt = 0; clksw_cyc = 0; ps_pulses = 0; ps_bad = 0;
        sc_rises = 0; busy_cyc = 0; last_clksw = -1; done_at = -1;
        ps_fall_at = -1; tmo_at = -1; ps_span = 0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observes pin activity at the inactive clock edge
    initial begin : monitor
        logic prev_sc, prev_ps, prev_tmo;
        prev_sc = 1'b0; prev_ps = 1'b0; prev_tmo = 1'b0;
        clear_mon();
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin done_cnt++; done_at = cyc; end
            if (err_badsel === 1'b1) bad_cnt++;
            if (clkswitch === 1'b1) begin clksw_cyc++; last_clksw = cyc; end
            if (busy === 1'b1) busy_cyc++;
            if (phasestep && !prev_ps) begin
                ps_pulses++;
                ps_span = 0;
                if (scanclk) ps_bad++;
            end
            if (scanclk && !prev_sc) begin
                sc_rises++;
                if (phasestep) ps_span++;
            end
            if (!phasestep && prev_ps) begin
                ps_fall_at = cyc;
                if (scanclk || ps_span != 2) ps_bad++;
            end
            if (err_timeout && !prev_tmo) tmo_at = cyc;
            prev_sc = scanclk; prev_ps = phasestep; prev_tmo = err_timeout;
        end
    end

    // PLL phasedone: goes low 5 cycles after the 2nd scanclk rise of a phasestep pulse, for 4 cycles
    initial begin : pll_model
        int rises, wait_c;
        logic prev_sc;
        phasedone = 1'b1; rises = 0; wait_c = -1; prev_sc = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                rises = 0; wait_c = -1; phasedone = 1'b1;
            end else if (wait_c >= 0) begin
                wait_c++;
                if (wait_c == 5 && !pd_stuck) phasedone = 1'b0;
                if (wait_c == 9) begin phasedone = 1'b1; wait_c = -1; end
            end else if (!phasestep) begin
                rises = 0;
            end else if (scanclk && !prev_sc) begin
                rises++;
                if (rises == 2) begin rises = 0; wait_c = 0; end
            end
            prev_sc = scanclk;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_apply(input logic op, input int sel, input logic dir, input int steps);
        int v;
        if (op || sel >= NUM_SEL) return;
        for (int i = 1; i < NUM_SEL; i++) begin
            if (sel == 0 || sel == i) begin
                v = model_ofs[i] + (dir ? steps : -steps);
                if (v > OMAX) v = OMAX;
                if (v < OMIN) v = OMIN;
                model_ofs[i] = v;
            end
        end
    endtask

    task automatic rule_expect(input logic op, input int sel, input int steps,
                               output int ed, output int eb, output int eps,
                               output int ecs, output int ebusy);
        ed = 0; eb = 0; eps = 0; ecs = 0; ebusy = 0;
        if (op) begin ed = 1; ecs = CLKSW_HOLD; ebusy = 1; end
        else if (sel >= NUM_SEL) eb = 1;
        else if (steps == 0) ed = 1;
        else begin ed = 1; eps = steps; ebusy = 1; end
    endtask

    task automatic read_ofs(input int idx, output logic [OFS_W-1:0] val);
        ofs_rd_sel = idx[SEL_W-1:0];
        @(posedge clk); #1;
        val = ofs_rd_data;
    endtask

    task automatic check_all_ofs(input string tag);
        logic [OFS_W-1:0] val;
        int exp;
        for (int idx = 0; idx < (1 << SEL_W); idx++) begin
            read_ofs(idx, val);
            exp = (idx >= 1 && idx < NUM_SEL) ? model_ofs[idx] : 0;
            check($sformatf("%s_ofs%0d", tag, idx), $signed(val), exp);
        end
    endtask

    task automatic run_cmd(input logic op, input int sel, input logic dir, input int steps, input int budget);
        int n;
        clear_mon();
        check("ready_before_cmd", cmd_ready, 1);
        cmd_op = op; cmd_sel = sel[SEL_W-1:0]; cmd_dir = dir;
        cmd_steps = steps[STEP_W-1:0]; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < budget);
        check("idle_within_budget", busy, 0);
    endtask

    task automatic check_counts(input string tag, input int ed, input int eb, input int eps,
                                input int ecs, input int ebusy);
        check({tag, "_done"}, done_cnt, ed);
        check({tag, "_badsel"}, bad_cnt, eb);
        check({tag, "_phasesteps"}, ps_pulses, eps);
        check({tag, "_clksw_cycles"}, clksw_cyc, ecs);
        check({tag, "_busy_seen"}, busy_cyc > 0, ebusy);
        check({tag, "_step_shape"}, ps_bad, 0);
        check({tag, "_scanclk_active"}, sc_rises > 0, eps > 0);
        if (ecs > 0) check({tag, "_done_after_clksw"}, done_at, last_clksw + 1);
    endtask

    initial begin : main
        vec_t vecs [6];
        int ed, eb, eps, ecs, ebusy, n, d;
        logic rop, rdir;
        int rsel, rsteps;

        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_sel = '0; cmd_dir = 1'b0;
        cmd_steps = '0; ofs_rd_sel = '0;
        for (int i = 0; i < NUM_SEL; i++) model_ofs[i] = 0;

        vecs[0] = '{1'b1, 0, 1'b0, 0, 1, 0, 0, CLKSW_HOLD, 1};
        vecs[1] = '{1'b0, 3, 1'b1, 3, 1, 0, 3, 0, 1};
        vecs[2] = '{1'b0, 0, 1'b0, 2, 1, 0, 2, 0, 1};
        vecs[3] = '{1'b0, 7, 1'b1, 4, 0, 1, 0, 0, 0};
        vecs[4] = '{1'b0, 5, 1'b0, 0, 1, 0, 0, 0, 0};
        vecs[5] = '{1'b0, 6, 1'b0, 1, 1, 0, 1, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_phasecounterselect", phasecounterselect, 0);
        check("rst_phaseupdown", phaseupdown, 1);
        check("rst_phasestep", phasestep, 0);
        check("rst_scanclk", scanclk, 0);
        check("rst_clkswitch", clkswitch, 0);
        check("rst_done", done, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_badsel", err_badsel, 0);
        check("rst_busy", busy, 0);
        check("rst_ofs_rd_data", ofs_rd_data, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check_all_ofs("reset");

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].op, vecs[i].sel, vecs[i].dir, vecs[i].steps, 2000);
            check_counts($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_bad,
                         vecs[i].exp_ps, vecs[i].exp_clksw, vecs[i].exp_busy);
            model_apply(vecs[i].op, vecs[i].sel, vecs[i].dir, vecs[i].steps);
            check_all_ofs($sformatf("vec%0d", i));
        end
        check("pins_hold_sel", phasecounterselect, 6);
        check("pins_hold_dir", phaseupdown, 0);

        // saturation: 2049 up steps, then more up (clamped), then one down (no wrap)
        run_cmd(1'b0, 2, 1'b1, 2049, 60000);
        check_counts("sat", 1, 0, 2049, 0, 1);
        model_apply(1'b0, 2, 1'b1, 2049);
        check_all_ofs("sat");
        run_cmd(1'b0, 2, 1'b1, 3, 2000);
        model_apply(1'b0, 2, 1'b1, 3);
        check_all_ofs("sat_hold");
        run_cmd(1'b0, 2, 1'b0, 1, 2000);
        model_apply(1'b0, 2, 1'b0, 1);
        check_all_ofs("sat_down");

        // timeout: phasedone never drops
        pd_stuck = 1'b1;
        run_cmd(1'b0, 4, 1'b1, 4, 6000);
        pd_stuck = 1'b0;
        check_counts("tmo", 1, 0, 1, 0, 1);
        check("tmo_err_timeout", err_timeout, 1);
        d = tmo_at - ps_fall_at;
        check("tmo_latency_in_window", (d >= DONE_TIMEOUT - 1 && d <= DONE_TIMEOUT + 1), 1);
        if (!(d >= DONE_TIMEOUT - 1 && d <= DONE_TIMEOUT + 1))
            $display("timeout latency measured %0d cycles", d);
        check_all_ofs("tmo");
        run_cmd(1'b0, 7, 1'b0, 1, 100);
        check("tmo_cleared_by_cmd", err_timeout, 0);
        check("tmo_clear_badsel", bad_cnt, 1);

        for (int r = 0; r < 14; r++) begin
            rop = ($urandom_range(0, 5) == 0);
            rsel = $urandom_range(0, (1 << SEL_W) - 1);
            rdir = $urandom_range(0, 1);
            rsteps = $urandom_range(0, 5);
            rule_expect(rop, rsel, rsteps, ed, eb, eps, ecs, ebusy);
            run_cmd(rop, rsel, rdir, rsteps, 2000);
            check_counts($sformatf("rnd%0d", r), ed, eb, eps, ecs, ebusy);
            model_apply(rop, rsel, rdir, rsteps);
            check_all_ofs($sformatf("rnd%0d", r));
        end

        // reset while phasestep is asserted
        clear_mon();
        cmd_op = 1'b0; cmd_sel = 3'd1; cmd_dir = 1'b1; cmd_steps = 12'd3; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!(phasestep && scanclk) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_reached_assert", phasestep && scanclk, 1);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("mid_phasestep", phasestep, 0);
        check("mid_scanclk", scanclk, 0);
        check("mid_busy", busy, 0);
        check("mid_cmd_ready", cmd_ready, 1);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_no_done", done_cnt, 0);
        for (int i = 0; i < NUM_SEL; i++) model_ofs[i] = 0;
        check_all_ofs("mid_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
